// File: rtl/plab3_mem_domain_guard.sv
// plab3_mem_domain_guard: security filter between a blocking L1 cache memory
// port and main memory. It handles one line request at a time. A non-secure
// request that targets the secure address window is answered locally with
// fail=1 and never reaches memory. Every other request is forwarded, and the
// memory response is relayed back to the cache.
// Optional feature: define PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN to add a
// saturating 16-bit count of denied requests (viol_count).
module plab3_mem_domain_guard #(
    parameter int              p_opaque_nbits = 8,
    parameter int              abw            = 32,
    parameter int              clw            = 128,
    parameter logic [abw-1:0]  p_sec_base     = 'h0000_1000,
    parameter logic [abw-1:0]  p_sec_bound    = 'h0000_2000,
    localparam int             lw             = $clog2(clw/8),
    localparam int             req_nbits      = 3 + p_opaque_nbits + abw + lw + clw,
    localparam int             resp_nbits     = 3 + p_opaque_nbits + 2 + lw + clw
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [req_nbits-1:0]  cmemreq_msg,
    input  logic                  cmemreq_val,
    output logic                  cmemreq_rdy,
    input  logic                  cmemreq_domain,
    output logic [resp_nbits-1:0] cmemresp_msg,
    output logic                  cmemresp_val,
    input  logic                  cmemresp_rdy,
    output logic                  cmemresp_domain,
    output logic                  fail,
    output logic [req_nbits-1:0]  memreq_msg,
    output logic                  memreq_val,
    input  logic                  memreq_rdy,
    output logic                  memreq_domain,
    input  logic [resp_nbits-1:0] memresp_msg,
    input  logic                  memresp_val,
    output logic                  memresp_rdy
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
    ,
    output logic [15:0]           viol_count
`endif
);

    typedef enum logic [2:0] {IDLE, FWD, WAIT, RESP, DENY} state_t;

    state_t                state, state_next;
    logic [req_nbits-1:0]  req_reg;
    logic                  dom_reg;
    logic [resp_nbits-1:0] resp_reg;

    logic [abw-1:0]        in_addr;
    logic                  violating;
    logic                  accept;
    logic [resp_nbits-1:0] deny_msg;

    // The window test is an unsigned compare on the full address. An empty
    // window (base >= bound) can never match.
    assign in_addr   = cmemreq_msg[clw+lw +: abw];
    assign violating = !cmemreq_domain && (in_addr >= p_sec_base) && (in_addr < p_sec_bound);
    assign accept    = cmemreq_val && cmemreq_rdy;

    // A local denial echoes the request type and opaque. Test, len and data are zero.
    assign deny_msg = {req_reg[req_nbits-1 -: 3+p_opaque_nbits], 2'b00, {lw{1'b0}}, {clw{1'b0}}};

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: one transaction in flight; each response returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)       state_next = violating ? DENY : FWD;
            FWD:     if (memreq_rdy)   state_next = WAIT;
            WAIT:    if (memresp_val)  state_next = RESP;
            RESP:    if (cmemresp_rdy) state_next = IDLE;
            DENY:    if (cmemresp_rdy) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Capture the request on accept and the memory response in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_reg  <= '0;
            dom_reg  <= 1'b0;
            resp_reg <= '0;
        end else begin
            if (accept) begin
                req_reg <= cmemreq_msg;
                dom_reg <= cmemreq_domain;
            end
            if (state == WAIT && memresp_val) resp_reg <= memresp_msg;
        end
    end

    // Outputs decode from state and registers only. The reset term in
    // cmemreq_rdy keeps the cache from handing over a request while the
    // guard is held in reset.
    always_comb begin
        cmemreq_rdy     = (state == IDLE) && reset;
        memreq_val      = (state == FWD);
        memreq_msg      = req_reg;
        memreq_domain   = (state == FWD) && dom_reg;
        memresp_rdy     = (state == WAIT);
        cmemresp_val    = (state == RESP) || (state == DENY);
        cmemresp_msg    = (state == DENY) ? deny_msg : resp_reg;
        cmemresp_domain = cmemresp_val && dom_reg;
        fail            = (state == DENY);
    end

`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
    // Saturating count of denied requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  viol_count <= '0;
        else if (accept && violating && viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_plab3_mem_domain_guard.sv
// Scoreboard bench for plab3_mem_domain_guard. Each transaction driven into
// the guard pushes the memory request and cache response it should produce.
// Negedge monitors pop those expectations on each handshake and compare them.
// Directed tasks check latency, back-pressure stability and reset behaviour.
module tb_plab3_mem_domain_guard;

    localparam int REQ_W  = 175;
    localparam int RESP_W = 145;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ_W-1:0]  cmemreq_msg;
    logic              cmemreq_val, cmemreq_rdy, cmemreq_domain;
    logic [RESP_W-1:0] cmemresp_msg;
    logic              cmemresp_val, cmemresp_rdy, cmemresp_domain, fail;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memreq_val, memreq_rdy, memreq_domain;
    logic [RESP_W-1:0] memresp_msg;
    logic              memresp_val, memresp_rdy;
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
    logic [15:0]       viol_count;
`endif

    typedef struct packed { logic [REQ_W-1:0] msg; logic dom; } mreq_t;
    typedef struct packed { logic [RESP_W-1:0] msg; logic fl; logic dom; } cresp_t;

    mreq_t  mq[$];
    cresp_t rq[$];
    int     checks   = 0;
    int     failures = 0;
    int     exp_viol = 0;

    plab3_mem_domain_guard dut (
        .clk(clk), .reset(reset),
        .cmemreq_msg(cmemreq_msg), .cmemreq_val(cmemreq_val), .cmemreq_rdy(cmemreq_rdy),
        .cmemreq_domain(cmemreq_domain),
        .cmemresp_msg(cmemresp_msg), .cmemresp_val(cmemresp_val), .cmemresp_rdy(cmemresp_rdy),
        .cmemresp_domain(cmemresp_domain), .fail(fail),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_domain(memreq_domain),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
        , .viol_count(viol_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: compare every handshake on both output ports.
    always @(negedge clk) begin
        mreq_t  em;
        cresp_t er;
        if (memreq_val && memreq_rdy) begin
            if (mq.size() == 0) chk("mreq_unexpected", 1, 0);
            else begin
                em = mq.pop_front();
                chk("mreq_msg", memreq_msg, em.msg);
                chk("mreq_dom", memreq_domain, em.dom);
            end
        end
        if (cmemresp_val && cmemresp_rdy) begin
            if (rq.size() == 0) chk("cresp_unexpected", 1, 0);
            else begin
                er = rq.pop_front();
                chk("cresp_msg", cmemresp_msg, er.msg);
                chk("cresp_fail", fail, er.fl);
                chk("cresp_dom", cmemresp_domain, er.dom);
            end
        end
    end

    // Present a request and wait (bounded) for it to be accepted.
    task automatic send_req(input logic [REQ_W-1:0] rm, input logic dom);
        int n;
        @(posedge clk); #1;
        cmemreq_msg = rm; cmemreq_domain = dom; cmemreq_val = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmemreq_rdy && n < 20) begin n++; @(negedge clk); end
        chk("accept_timeout", n < 20, 1);
        @(posedge clk); #1 cmemreq_val = 1'b0;
    endtask

    // One full transaction with optional back-pressure on both output ports.
    task automatic xact(input logic [2:0] typ, input logic [7:0] op, input logic [31:0] addr,
                        input logic [127:0] d, input logic dom, input logic [127:0] rd,
                        input int mhold, input int chold);
        logic              viol;
        logic [REQ_W-1:0]  rm;
        logic [RESP_W-1:0] pm;
        viol = !dom && addr >= 32'h0000_1000 && addr < 32'h0000_2000;
        rm   = {typ, op, addr, 4'd0, d};
        pm   = viol ? {typ, op, 2'b00, 4'd0, 128'd0} : {typ, op, 2'b00, 4'd0, rd};
        if (!viol) mq.push_back('{rm, dom});
        rq.push_back('{pm, viol, dom});
        if (viol) exp_viol++;
        send_req(rm, dom);
        @(negedge clk);
        chk("mreq_val_t1", memreq_val, !viol);
        chk("cresp_val_t1", cmemresp_val, viol);
        chk("creq_rdy_busy", cmemreq_rdy, 0);
        if (!viol) begin
            for (int i = 0; i < mhold; i++) begin
                @(negedge clk);
                chk("mreq_hold_msg", memreq_msg, rm);
                chk("mreq_hold_val", memreq_val, 1);
                chk("creq_rdy_hold", cmemreq_rdy, 0);
            end
            @(posedge clk); #1 memreq_rdy = 1'b1;
            @(posedge clk); #1 memreq_rdy = 1'b0;
            memresp_msg = pm; memresp_val = 1'b1;
            @(negedge clk);
            chk("mresp_rdy_wait", memresp_rdy, 1);
            chk("cresp_val_wait", cmemresp_val, 0);
            @(posedge clk); #1 memresp_val = 1'b0;
            @(negedge clk);
            chk("cresp_val_m1", cmemresp_val, 1);
        end
        for (int i = 0; i < chold; i++) begin
            @(negedge clk);
            chk("cresp_hold_msg", cmemresp_msg, pm);
            chk("cresp_hold_val", cmemresp_val, 1);
            chk("cresp_hold_fail", fail, viol);
            chk("mreq_quiet", memreq_val, 0);
        end
        @(posedge clk); #1 cmemresp_rdy = 1'b1;
        @(posedge clk); #1 cmemresp_rdy = 1'b0;
        @(negedge clk);
        chk("idle_rdy", cmemreq_rdy, 1);
        chk("idle_cresp_val", cmemresp_val, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end

    initial begin
        logic [REQ_W-1:0] rm;
        reset = 1'b0; cmemreq_msg = '0; cmemreq_val = 1'b0; cmemreq_domain = 1'b0;
        cmemresp_rdy = 1'b0; memreq_rdy = 1'b0; memresp_msg = '0; memresp_val = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_creq_rdy", cmemreq_rdy, 0);
        chk("rst_mreq_val", memreq_val, 0);
        chk("rst_cresp_val", cmemresp_val, 0);
        chk("rst_fail", fail, 0);
        chk("rst_mresp_rdy", memresp_rdy, 0);
        chk("rst_doms", {memreq_domain, cmemresp_domain}, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", cmemreq_rdy, 1);

        // permitted read, secure write, denied at base
        xact(3'd0, 8'h05, 32'h0000_0400, '0, 1'b0, {16{8'hA5}}, 0, 0);
        xact(3'd1, 8'h06, 32'h0000_1800, {4{32'hDEAD_BEEF}}, 1'b1, 128'h0, 0, 0);
        xact(3'd0, 8'h05, 32'h0000_1000, '0, 1'b0, 128'h0, 0, 0);
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
        chk("viol_count_1", viol_count, 16'd1);
`endif
        // window edges
        xact(3'd0, 8'h07, 32'h0000_1FFF, '0, 1'b0, 128'h0, 0, 0);
        xact(3'd0, 8'h08, 32'h0000_2000, '0, 1'b0, {4{32'h1234_5678}}, 0, 0);
        // back-pressure on both sides
        xact(3'd1, 8'h09, 32'h0000_0040, {4{32'hCAFE_F00D}}, 1'b0, 128'h55, 5, 3);
        xact(3'd0, 8'h0A, 32'h0000_1ABC, '0, 1'b0, 128'h0, 0, 3);
        // other request types
        xact(3'd3, 8'h0B, 32'h0000_0FFF, 128'h77, 1'b0, 128'h99, 1, 1);
        xact(3'd2, 8'h0C, 32'h0000_1004, 128'h11, 1'b0, 128'h0, 0, 0);
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
        chk("viol_count_n", viol_count, 16'(exp_viol));
`endif

        // reset while waiting on memory
        rm = {3'd0, 8'h0D, 32'h0000_0100, 4'd0, 128'd0};
        mq.push_back('{rm, 1'b0});
        send_req(rm, 1'b0);
        @(posedge clk); #1 memreq_rdy = 1'b1;
        @(posedge clk); #1 memreq_rdy = 1'b0;
        @(negedge clk);
        chk("wait_mresp_rdy", memresp_rdy, 1);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("midrst_vals", {memreq_val, cmemresp_val, memresp_rdy, cmemreq_rdy, fail}, 0);
        exp_viol = 0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        memresp_msg = {3'd0, 8'h0D, 2'b00, 4'd0, 128'hBAD}; memresp_val = 1'b1;
        @(posedge clk); #1 memresp_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_cresp", cmemresp_val, 0);
        end
        xact(3'd0, 8'h0E, 32'h0000_0200, '0, 1'b0, 128'hF00, 0, 0);
`ifdef PLAB3_MEM_DOMAIN_GUARD_VIOLATION_CNT_EN
        chk("viol_count_rst", viol_count, 16'(exp_viol));
`endif
        chk("sb_empty", mq.size() + rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
